// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives InstructionMemory and fills the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating FetchCount/StallCount outputs.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_VEC  = 32'h00000000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] NOP_INST   = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    output logic [31:0] Inst_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic        AddrErr
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_range;

    logic        do_redirect;
    logic [31:0] redirect_tgt;
    logic        do_advance;
    logic        do_load;
    logic        do_oor;
    logic        do_stall;
    logic        misaligned;

    assign Addr     = pc;
    assign pc_plus4 = pc + 32'd4;
    assign in_range = (pc < PC_LIMIT);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Branch beats Jump beats Stall; BOOT ignores all control inputs.
    always_comb begin
        do_redirect  = 1'b0;
        redirect_tgt = '0;
        do_advance   = 1'b0;
        do_load      = 1'b0;
        do_oor       = 1'b0;
        do_stall     = 1'b0;
        if (state == RUN) begin
            if (Branch) begin
                do_redirect  = 1'b1;
                redirect_tgt = BranchTarget;
            end else if (Jump) begin
                do_redirect  = 1'b1;
                redirect_tgt = JumpTarget;
            end else if (Stall) begin
                do_stall = 1'b1;
            end else begin
                do_advance = 1'b1;
                do_load    = in_range;
                do_oor     = ~in_range;
            end
        end
    end

    assign misaligned = do_redirect && (redirect_tgt[1:0] != 2'b00);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc         <= RESET_VEC;
            Inst_ID    <= NOP_INST;
            PCPlus4_ID <= '0;
            Valid_ID   <= 1'b0;
            AddrErr    <= 1'b0;
        end else begin
            if (do_redirect) begin
                pc       <= {redirect_tgt[31:2], 2'b00};
                Inst_ID  <= NOP_INST;
                Valid_ID <= 1'b0;
            end else if (do_advance) begin
                pc         <= pc_plus4;
                PCPlus4_ID <= pc_plus4;
                Inst_ID    <= do_load ? Inst : NOP_INST;
                Valid_ID   <= do_load;
            end
            if (misaligned || do_oor) AddrErr <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (do_load && (FetchCount != '1)) FetchCount <= FetchCount + 32'd1;
            if (do_stall && (StallCount != '1)) StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus random
// control traffic compared against a behavioural fetch model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] inst_id;
    logic [31:0] pcplus4_id;
    logic        valid_id;
    logic        addr_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:255];

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // reference model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_err, m_boot;
    int unsigned m_fetches, m_stalls;

    instruction_fetch_stage #(
        .RESET_VEC (32'h00000000),
        .IMEM_WORDS(256),
        .NOP_INST  (32'h00000000)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Stall       (stall),
        .Branch      (branch),
        .BranchTarget(branch_target),
        .Jump        (jump),
        .JumpTarget  (jump_target),
        .Inst        (inst),
        .Addr        (addr),
        .Inst_ID     (inst_id),
        .PCPlus4_ID  (pcplus4_id),
        .Valid_ID    (valid_id),
`ifdef FETCH_PERF_CNT_EN
        .FetchCount  (fetch_count),
        .StallCount  (stall_count),
`endif
        .AddrErr     (addr_err)
    );

    always #5 clk = ~clk;

    // combinational instruction memory; out-of-range reads return junk
    assign inst = (addr < 32'h400) ? mem[addr[9:2]] : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Addr"},       addr,       m_pc);
        chk({tag, ".Inst_ID"},    inst_id,    m_inst);
        chk({tag, ".PCPlus4_ID"}, pcplus4_id, m_pc4);
        chk({tag, ".Valid_ID"},   {31'd0, valid_id}, {31'd0, m_valid});
        chk({tag, ".AddrErr"},    {31'd0, addr_err}, {31'd0, m_err});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".FetchCount"}, fetch_count, m_fetches);
        chk({tag, ".StallCount"}, stall_count, m_stalls);
`endif
    endtask

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_boot = 1;
        m_fetches = 0; m_stalls = 0;
    endtask

    // called #1 after a posedge: asserts reset asynchronously, then releases it
    task automatic do_reset(input string tag);
        rst = 1'b1;
        stall = 0; branch = 0; jump = 0;
        model_reset();
        #2;
        check_all({tag, "_async"});
        repeat (3) @(posedge clk);
        #1;
        check_all({tag, "_held"});
        rst = 1'b0;
    endtask

    task automatic step(input string tag, input logic st, input logic br, input logic jp,
                        input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] tgt;
        stall = st; branch = br; jump = jp; branch_target = bt; jump_target = jt;
        if (m_boot) begin
            m_boot = 0;
        end else if (br || jp) begin
            tgt = br ? bt : jt;
            if (tgt % 4 != 0) m_err = 1;
            m_pc    = tgt - (tgt % 4);
            m_inst  = 32'h0;
            m_valid = 0;
        end else if (st) begin
            m_stalls++;
        end else begin
            if (m_pc < 256 * 4) begin
                m_inst  = mem[m_pc / 4];
                m_valid = 1;
                m_fetches++;
            end else begin
                m_inst  = 32'h0;
                m_valid = 0;
                m_err   = 1;
            end
            m_pc4 = m_pc + 4;
            m_pc  = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic st, br, jp;
        foreach (mem[i]) mem[i] = $urandom;
        mem[0] = 32'h20080005;

        // initial power-up reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        step("boot_ignores_ctrl", 1, 1, 1, 32'h40, 32'h80);
        step("first_fetch", 0, 0, 0, 0, 0);
        repeat (3) step("seq", 0, 0, 0, 0, 0);
        chk("at_0x10", addr, 32'h10);
        repeat (3) step("stall", 1, 0, 0, 0, 0);
        step("stall_release", 0, 0, 0, 0, 0);
        repeat (6) step("seq2", 0, 0, 0, 0, 0);

        step("br_jmp_stall", 1, 1, 1, 32'h40, 32'h80);
        step("after_branch", 0, 0, 0, 0, 0);

        step("jump_3fc", 0, 0, 1, 0, 32'h3FC);
        step("fetch_3fc", 0, 0, 0, 0, 0);
        step("fetch_400", 0, 0, 0, 0, 0);
        step("jump_22", 0, 0, 1, 0, 32'h22);
        step("after_22", 0, 0, 0, 0, 0);

        // mid-run reset, then the perf-counter scenario
        do_reset("midrun_reset");
        step("boot2", 0, 0, 0, 0, 0);
        repeat (5) step("perf_fetch", 0, 0, 0, 0, 0);
        repeat (2) step("perf_stall", 1, 0, 0, 0, 0);
        step("perf_branch", 0, 1, 0, 32'h8, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_5", fetch_count, 32'd5);
        chk("perf_stall_2", stall_count, 32'd2);
`endif

        // random control traffic, one reset partway through
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                do_reset("rand_reset");
            end
            st = ($urandom % 4) == 0;
            br = ($urandom % 10) == 0;
            jp = ($urandom % 10) == 0;
            step("rand", st, br, jp, $urandom_range(0, 32'h43F), $urandom_range(0, 32'h43F));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
